row_scan_ctrl: RTL and testbench
================================

# row_scan_ctrl

Sequencer that drives the 3-bit channel select of the downstream 3-to-8 active-low line decoder. It steps through an enabled subset of 8 channels in ascending order. Each channel gets a programmable dwell time, and a fixed blanking gap precedes every channel so drivers are off while the select changes. Single-shot or continuous frames are supported, with a frame-done pulse and an empty-mask error flag.

## Interface
Parameters:
- DWELL_W, 16, width of dwell count
- BLANK_CYC, 2, blanking cycles before each channel; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; low forces IDLE
- start  in  1  begin frame (sampled in IDLE only)
- mode_cont  in  1  1 = continuous frames, 0 = single frame; sampled at frame start
- mask  in  8  channel enable, bit i = channel i; snapshotted at frame start
- dwell  in  DWELL_W  dwell cycles per channel; snapshotted at frame start; 0 treated as 1
- sel  out  3  current channel index to decoder
- sel_vld  out  1  high during dwell: decoder output is live
- blank  out  1  high when drivers must be off (IDLE or BLANK)
- busy  out  1  high in BLANK or DWELL
- frame_done  out  1  one-cycle pulse on last dwell cycle of last enabled channel
- err_empty  out  1  one-cycle pulse when a frame start finds mask == 0

## Operation
- All outputs registered.
- Reset values:
  - sel = 0, sel_vld = 0, blank = 1, busy = 0, frame_done = 0, err_empty = 0
  - state = IDLE, all counters and snapshots = 0
- States are IDLE, BLANK and DWELL.
- IDLE:
  - start & en & mask != 0: snapshot mask/dwell/mode_cont, cur = lowest set bit, count = BLANK_CYC−1, go BLANK.
  - start & en & mask == 0: err_empty pulse, stay IDLE.
  - start while en = 0 is ignored.
- BLANK:
  - Outputs: sel = cur, blank = 1, sel_vld = 0.
  - count == 0: load count = max(dwell_snap,1)−1, go DWELL.
  - Otherwise decrement.
- DWELL:
  - Outputs: sel = cur, blank = 0, sel_vld = 1.
  - On count == 0 with a higher enabled channel: cur = next set bit above cur, go BLANK.
  - On count == 0 with none higher: frame_done pulse this cycle.
    - Continuous: re-snapshot mask/dwell and restart from the lowest set bit. If the new mask == 0, pulse err_empty next cycle and go IDLE.
    - Single-shot: go IDLE.
- en low in any state: IDLE next edge, no frame_done, sel holds last value, sel_vld = 0, blank = 1.
- start while busy is ignored. mask/dwell changes mid-frame have no effect until the next snapshot.
- Counter widths: BLANK counter is 4 bits; dwell counter is DWELL_W bits. No wrap, because the load value is always ≤ max.

## Timing
- Start sampled at edge T → busy = 1, blank = 1, sel = first channel from T+1.
- sel_vld rises at T+1+BLANK_CYC and stays high for max(dwell,1) cycles.
- Per-channel slot = BLANK_CYC + max(dwell,1) cycles.
- Frame length = N_enabled × slot.
- Continuous mode has no idle gap between frames.
- sel changes only on entry to BLANK, never while sel_vld = 1.
- frame_done coincides with the last sel_vld cycle of the frame.
- Single-shot: busy falls on the edge after frame_done.
- Reset mid-operation immediately returns all outputs to reset values, asynchronously.

## Structure
- Package row_scan_pkg:
  - NUM_CH = 8, CH_W = 3
  - state enum {IDLE, BLANK, DWELL}
- Sub-module next_chan_find: combinational priority search.
  - Inputs: mask[7:0], cur[2:0], from_start.
  - Outputs: nxt[2:0], found.
  - Returns the lowest set bit when from_start = 1, otherwise the lowest set bit strictly above cur.
- Top contains the FSM, counters and snapshot registers.

## Test plan
- Reset: assert rst mid-DWELL → same cycle sel = 0, sel_vld = 0, blank = 1, busy = 0; stays IDLE after release until start.
- Single-shot, mask = 8'hFF, dwell = 3, BLANK_CYC = 2:
  - sel steps 0..7, each with 2 blank + 3 valid cycles; frame = 40 cycles.
  - frame_done on cycle 40; busy low on cycle 41.
- Sparse mask = 8'b1000_0101, dwell = 0:
  - Visits channels 0, 2, 7 only, each with 1 valid cycle.
  - frame_done on channel 7's valid cycle.
- Continuous mode: change mask to 8'h10 during frame 1 → frame 2 begins the cycle after frame_done with sel = 4 only; then set mask = 0 → err_empty pulse and return to IDLE after frame 2.
- Start with mask = 0 → err_empty pulse 1 cycle, busy stays 0; start while busy → ignored, sequence unchanged.
- Drop en mid-DWELL on channel 3 → IDLE next edge, no frame_done, sel_vld = 0, blank = 1.

Source files
------------

// File: rtl/row_scan_pkg.sv
// Shared types and sizes for the row scan sequencer.
// Channel count and select width of the downstream 3-to-8 decoder.
package row_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/row_scan_ctrl_next_chan_find.sv
// Priority search for the next enabled channel in a mask.
// Purely combinational, zero latency; no flow control.
// Returns the lowest set bit, or the lowest set bit strictly above cur.
module next_chan_find
    import row_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_start,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    // Walk downward so the lowest qualifying bit is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_scan_ctrl.sv
// Steps the decoder select through enabled channels with blanking and dwell.
// All outputs registered: first channel appears one cycle after start.
// No backpressure; start is ignored while busy, en low aborts to IDLE.
module row_scan_ctrl
    import row_scan_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               mode_cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_vld,
    output logic               blank,
    output logic               busy,
    output logic               frame_done,
    output logic               err_empty
);

    localparam logic [3:0] BLANK_LD = 4'(BLANK_CYC - 1);

    state_t               state;
    logic [CH_W-1:0]      cur;
    logic [NUM_CH-1:0]    mask_snap;
    logic [DWELL_W-1:0]   dwell_snap;
    logic                 mode_snap;
    logic [3:0]           bcnt;
    logic [DWELL_W-1:0]   dcnt;

    logic [CH_W-1:0]      hi_nxt;
    logic                 hi_found;
    logic [CH_W-1:0]      st_nxt;
    logic                 st_found;
    logic [DWELL_W-1:0]   dwell_ld;

    // Next channel within the current frame's snapshot.
    next_chan_find u_find_hi (
        .mask       (mask_snap),
        .cur        (cur),
        .from_start (1'b0),
        .nxt        (hi_nxt),
        .found      (hi_found)
    );

    // First channel of a new frame, taken from the live mask being snapshotted.
    next_chan_find u_find_start (
        .mask       (mask),
        .cur        (cur),
        .from_start (1'b1),
        .nxt        (st_nxt),
        .found      (st_found)
    );

    // A programmed dwell of zero still gets one live cycle.
    assign dwell_ld = (dwell_snap == '0) ? '0 : dwell_snap - DWELL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            mask_snap  <= '0;
            dwell_snap <= '0;
            mode_snap  <= 1'b0;
            bcnt       <= '0;
            dcnt       <= '0;
            sel        <= '0;
            sel_vld    <= 1'b0;
            blank      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_empty  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_empty  <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                sel_vld <= 1'b0;
                blank   <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (st_found) begin
                                mask_snap  <= mask;
                                dwell_snap <= dwell;
                                mode_snap  <= mode_cont;
                                cur        <= st_nxt;
                                sel        <= st_nxt;
                                bcnt       <= BLANK_LD;
                                state      <= BLANK;
                                busy       <= 1'b1;
                                blank      <= 1'b1;
                            end else begin
                                err_empty <= 1'b1;
                            end
                        end
                    end
                    BLANK: begin
                        if (bcnt == 4'd0) begin
                            dcnt       <= dwell_ld;
                            state      <= DWELL;
                            sel_vld    <= 1'b1;
                            blank      <= 1'b0;
                            frame_done <= (dwell_ld == '0) && !hi_found;
                        end else begin
                            bcnt <= bcnt - 4'd1;
                        end
                    end
                    DWELL: begin
                        if (dcnt == '0) begin
                            sel_vld <= 1'b0;
                            blank   <= 1'b1;
                            if (hi_found) begin
                                cur   <= hi_nxt;
                                sel   <= hi_nxt;
                                bcnt  <= BLANK_LD;
                                state <= BLANK;
                            end else if (mode_snap) begin
                                // Back-to-back frame: fresh snapshot, no idle gap.
                                mask_snap  <= mask;
                                dwell_snap <= dwell;
                                mode_snap  <= mode_cont;
                                if (st_found) begin
                                    cur   <= st_nxt;
                                    sel   <= st_nxt;
                                    bcnt  <= BLANK_LD;
                                    state <= BLANK;
                                end else begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    err_empty <= 1'b1;
                                end
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            dcnt       <= dcnt - DWELL_W'(1);
                            // Registered, so flag the cycle that is about to be the last.
                            frame_done <= (dcnt == DWELL_W'(1)) && !hi_found;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Directed bench for row_scan_ctrl; each observation is the packed output
// vector {sel, sel_vld, blank, busy, frame_done, err_empty}.
module tb_row_scan_ctrl;

    localparam int DWELL_W   = 16;
    localparam int BLANK_CYC = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b1;
    logic               start = 1'b0;
    logic               mode_cont = 1'b0;
    logic [7:0]         mask = 8'h00;
    logic [DWELL_W-1:0] dwell = '0;
    logic [2:0]         sel;
    logic               sel_vld;
    logic               blank;
    logic               busy;
    logic               frame_done;
    logic               err_empty;

    int nvec = 0;
    int nerr = 0;

    row_scan_ctrl #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .mode_cont  (mode_cont),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_vld    (sel_vld),
        .blank      (blank),
        .busy       (busy),
        .frame_done (frame_done),
        .err_empty  (err_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {sel, sel_vld, blank, busy, frame_done, err_empty};
    endfunction

    // Expected outputs on cycle c (1 = first cycle after the start edge) of a single frame.
    function automatic logic [7:0] exp_vec(int c, logic [7:0] msk, int dw);
        int n, slot, k, pos, seen;
        logic [2:0] ch, last;
        logic vld;
        n = 0;
        last = 3'd0;
        for (int i = 0; i < 8; i++) if (msk[i]) begin n++; last = 3'(i); end
        slot = BLANK_CYC + ((dw == 0) ? 1 : dw);
        if (c > n * slot) return {last, 5'b01000};
        k = (c - 1) / slot;
        pos = (c - 1) % slot;
        seen = 0;
        ch = 3'd0;
        for (int i = 0; i < 8; i++) if (msk[i]) begin
            if (seen == k) ch = 3'(i);
            seen++;
        end
        vld = (pos >= BLANK_CYC);
        return {ch, vld, !vld, 1'b1, (c == n * slot), 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] m, input int dw, input logic cont);
        mask = m;
        dwell = DWELL_W'(dw);
        mode_cont = cont;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got = obs();
        nvec++;
        if (got !== 8'b000_01000) begin
            nerr++;
            $display("FAIL reset_values: got %b want %b", got, 8'b000_01000);
        end
        do_start(8'hFF, 3, 1'b0);
        step();
        step();
        got = obs();
        nvec++;
        if (got !== exp_vec(3, 8'hFF, 3)) begin
            nerr++;
            $display("FAIL reset_pre_dwell: got %b want %b", got, exp_vec(3, 8'hFF, 3));
        end
        #2 rst = 1'b1;
        #1;
        got = obs();
        nvec++;
        if (got !== 8'b000_01000) begin
            nerr++;
            $display("FAIL reset_async: got %b want %b", got, 8'b000_01000);
        end
        step();
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            got = obs();
            nvec++;
            if (got !== 8'b000_01000) begin
                nerr++;
                $display("FAIL reset_stay_idle cyc %0d: got %b want %b", c, got, 8'b000_01000);
            end
        end
    endtask

    task automatic test_single_full();
        logic [7:0] got;
        do_start(8'hFF, 3, 1'b0);
        for (int c = 1; c <= 42; c++) begin
            got = obs();
            nvec++;
            if (got !== exp_vec(c, 8'hFF, 3)) begin
                nerr++;
                $display("FAIL single_ff cyc %0d: got %b want %b", c, got, exp_vec(c, 8'hFF, 3));
            end
            step();
        end
    endtask

    task automatic test_sparse();
        logic [7:0] got;
        do_start(8'b1000_0101, 0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            got = obs();
            nvec++;
            if (got !== exp_vec(c, 8'b1000_0101, 0)) begin
                nerr++;
                $display("FAIL sparse cyc %0d: got %b want %b", c, got, exp_vec(c, 8'b1000_0101, 0));
            end
            step();
        end
    endtask

    task automatic test_continuous();
        logic [7:0] got, exp;
        do_start(8'h05, 1, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            if (c <= 6)       exp = exp_vec(c, 8'h05, 1);
            else if (c <= 9)  exp = exp_vec(c - 6, 8'h10, 1);
            else if (c == 10) exp = 8'b100_01001;
            else              exp = 8'b100_01000;
            got = obs();
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL continuous cyc %0d: got %b want %b", c, got, exp);
            end
            if (c == 2) mask = 8'h10;
            if (c == 7) mask = 8'h00;
            step();
        end
        mode_cont = 1'b0;
    endtask

    task automatic test_empty_and_busy_start();
        logic [7:0] got;
        en = 1'b0;
        do_start(8'h05, 1, 1'b0);
        got = obs();
        nvec++;
        if (got !== 8'b100_01000) begin
            nerr++;
            $display("FAIL start_while_disabled: got %b want %b", got, 8'b100_01000);
        end
        en = 1'b1;
        step();
        do_start(8'h00, 1, 1'b0);
        got = obs();
        nvec++;
        if (got !== 8'b100_01001) begin
            nerr++;
            $display("FAIL empty_pulse: got %b want %b", got, 8'b100_01001);
        end
        step();
        got = obs();
        nvec++;
        if (got !== 8'b100_01000) begin
            nerr++;
            $display("FAIL empty_one_cycle: got %b want %b", got, 8'b100_01000);
        end
        do_start(8'h06, 2, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            got = obs();
            nvec++;
            if (got !== exp_vec(c, 8'h06, 2)) begin
                nerr++;
                $display("FAIL busy_start cyc %0d: got %b want %b", c, got, exp_vec(c, 8'h06, 2));
            end
            if (c == 3) begin
                mask = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_en_drop();
        logic [7:0] got, exp;
        do_start(8'hFF, 3, 1'b0);
        for (int c = 1; c <= 23; c++) begin
            exp = (c <= 18) ? exp_vec(c, 8'hFF, 3) : 8'b011_01000;
            got = obs();
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL en_drop cyc %0d: got %b want %b", c, got, exp);
            end
            if (c == 18) en = 1'b0;
            step();
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_full();
        test_sparse();
        test_continuous();
        test_empty_and_busy_start();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
